vedic_mul4_pipe: RTL and testbench
==================================

VEDIC_MUL4_PIPE -- requirements
Module: vedic_mul4_pipe

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: operands 4 bits, product 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream presents a valid operand pair on a/b.
REQ-005 in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 a  input  4  multiplicand, unsigned.
REQ-007 b  input  4  multiplier, unsigned.
REQ-008 out_valid  output  1  p holds a valid product.
REQ-009 out_ready  input  1  downstream consumes p this cycle.
REQ-010 p  output  8  unsigned product a*b.

Function
REQ-011 An operand pair SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-012 A product SHALL be delivered on a rising edge where out_valid and out_ready are both 1.
REQ-013 The block SHALL have two register stages: S1 (partial products) and S2 (final product); an accepted pair SHALL appear on p with out_valid=1 exactly 2 cycles after acceptance when out_ready is held at 1.
REQ-014 S1 SHALL register four 4-bit Urdhva-Tiryagbhyam partial products: q0=a[1:0]*b[1:0], q1=a[3:2]*b[1:0], q2=a[1:0]*b[3:2], q3=a[3:2]*b[3:2], plus valid bit s1_v.
REQ-015 S2 SHALL register p = q0 + ((q1+q2) << 2) + (q3 << 4), computed at 8 bits with no truncation of intermediate sums; out_valid is the S2 valid bit.
REQ-016 Stage enables: s2_en = !out_valid | out_ready; s1_en = !s1_v | s2_en; in_ready = s1_en (combinational from out_ready, permitted).
REQ-017 When s2_en=1, S2 SHALL load S1 contents and valid; when s1_en=1, S1 SHALL load new partial products with s1_v = in_valid.
REQ-018 With out_ready held at 1, throughput SHALL be one product per cycle with no bubbles.
REQ-019 While out_valid=1 and out_ready=0, p and out_valid SHALL hold stable; S1 SHALL fill if empty, then in_ready SHALL drop to 0.
REQ-020 Simultaneous accept and deliver in the same cycle with both stages full SHALL lose and duplicate no product.
REQ-021 Products SHALL be delivered in acceptance order.
REQ-022 Data registers MAY hold stale values while their valid bit is 0; only valid bits are observable contract.

Reset
REQ-023 rst_n=0 SHALL immediately clear s1_v and out_valid to 0 and force p to 8'h00, regardless of clk.
REQ-024 Any product in flight at reset assertion SHALL be discarded and never delivered.
REQ-025 Following rst_n deassertion, in_ready SHALL be 1 in the first cycle; the first accepted pair SHALL follow REQ-013 latency.

Structure
REQ-026 A shared package vedic_pkg SHALL hold OPW=4, PW=8, HALFW=2 and the partial-product type (4-bit unsigned).
REQ-027 One sub-module vedic_mul2 (2x2 Vedic multiplier: AND terms plus two half adders, purely combinational, 4-bit output) SHALL be instantiated four times for q0..q3.
REQ-028 Only S1 and S2 SHALL contain flops; no other storage is permitted.

Verification
REQ-029 a=3,b=5, in_valid for 1 cycle, out_ready=1 -> out_valid=1 with p=15 (8'h0F) exactly 2 cycles later, then out_valid=0.
REQ-030 Exhaustive sweep of all 256 pairs back-to-back with out_ready=1 -> 256 products in order, each p=a*b (15x15=225=8'hE1), one per cycle.
REQ-031 Stream 10x10, 7x9, 12x4 with out_ready=0 for 5 cycles -> p=100 held stable, in_ready=0 after S1 fills; on out_ready=1, p sequence 100, 63, 48.
REQ-032 Random in_valid/out_ready toggling, 10k pairs -> scoreboard matches, no loss or duplicate, p stable while stalled.
REQ-033 Assert rst_n=0 mid-clock with both stages full (6x6, 9x2) -> out_valid and p go to 0 immediately; neither 36 nor 18 ever delivered after release.
REQ-034 a=0,b=15 and a=15,b=0 -> p=0 with out_valid=1 (zero product distinguished from empty only by out_valid).

Source files
------------

// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and partial-product type for the Vedic multiplier
package vedic_pkg;

    localparam int OPW   = 4;
    localparam int PW    = 8;
    localparam int HALFW = 2;

    // One 2x2 Urdhva-Tiryagbhyam partial product (max 3*3 = 9)
    typedef logic [OPW-1:0] pp_t;

endpackage

// File: rtl/vedic_mul2.sv
// rtl/vedic_mul2.sv - combinational 2x2 Vedic multiplier (AND terms plus two half adders)
module vedic_mul2
    import vedic_pkg::*;
(
    input  logic [HALFW-1:0] a,
    input  logic [HALFW-1:0] b,
    output pp_t              q
);

    logic t_lo;
    logic t_cross0;
    logic t_cross1;
    logic t_hi;
    logic c_mid;

    assign t_lo     = a[0] & b[0];
    assign t_cross0 = a[1] & b[0];
    assign t_cross1 = a[0] & b[1];
    assign t_hi     = a[1] & b[1];

    // First half adder sums the two crosswise terms
    assign c_mid = t_cross0 & t_cross1;

    // Second half adder folds the crosswise carry into the vertical high term
    assign q = {t_hi & c_mid, t_hi ^ c_mid, t_cross0 ^ t_cross1, t_lo};

endmodule

// File: rtl/vedic_mul4_pipe.sv
// rtl/vedic_mul4_pipe.sv - two-stage valid/ready pipelined 4x4 Vedic multiplier
module vedic_mul4_pipe
    import vedic_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] p
);

    pp_t q0_c, q1_c, q2_c, q3_c;
    pp_t s1_q0, s1_q1, s1_q2, s1_q3;
    logic s1_v;
    logic s1_en;
    logic s2_en;

    logic [PW-1:0] q0_w, q1_w, q2_w, q3_w;
    logic [PW-1:0] mid_w;
    logic [PW-1:0] p_next;

    vedic_mul2 u_q0 (.a(a[1:0]), .b(b[1:0]), .q(q0_c));
    vedic_mul2 u_q1 (.a(a[3:2]), .b(b[1:0]), .q(q1_c));
    vedic_mul2 u_q2 (.a(a[1:0]), .b(b[3:2]), .q(q2_c));
    vedic_mul2 u_q3 (.a(a[3:2]), .b(b[3:2]), .q(q3_c));

    // A stage may load when it is empty or its contents leave this cycle
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_v || s2_en;
    assign in_ready = s1_en;

    // Recombine partial products at full product width so no carry is lost
    assign q0_w   = {{(PW-OPW){1'b0}}, s1_q0};
    assign q1_w   = {{(PW-OPW){1'b0}}, s1_q1};
    assign q2_w   = {{(PW-OPW){1'b0}}, s1_q2};
    assign q3_w   = {{(PW-OPW){1'b0}}, s1_q3};
    assign mid_w  = q1_w + q2_w;
    assign p_next = q0_w + (mid_w << 2) + (q3_w << 4);

    // S1 valid bit: cleared by reset, otherwise tracks upstream when S1 may load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
        end else if (s1_en) begin
            s1_v <= in_valid;
        end
    end

    // S1 partial products: payload only, meaningful solely while s1_v is set
    always_ff @(posedge clk) begin
        if (s1_en) begin
            s1_q0 <= q0_c;
            s1_q1 <= q1_c;
            s1_q2 <= q2_c;
            s1_q3 <= q3_c;
        end
    end

    // S2 final product and valid: held while downstream stalls, zeroed by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            p         <= '0;
        end else if (s2_en) begin
            out_valid <= s1_v;
            p         <= p_next;
        end
    end

endmodule

// File: tb/tb_vedic_mul4_pipe.sv
// tb/tb_vedic_mul4_pipe.sv - self-checking bench for vedic_mul4_pipe
module tb_vedic_mul4_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    vedic_mul4_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    // One clock: drive at negedge, sample just after, model accepted pairs as plain a*b
    task automatic cycle(input logic v, input logic [3:0] ai, input logic [3:0] bi,
                         input logic ordy, output logic acc, output logic dlv,
                         output logic ov, output logic ir, output logic [7:0] pv);
        @(negedge clk);
        in_valid  = v;
        a         = ai;
        b         = bi;
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        dlv = out_valid & out_ready;
        ov  = out_valid;
        ir  = in_ready;
        pv  = p;
        if (acc) exp_q.push_back(int'(ai) * int'(bi));
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 4'd0;
        b         = 4'd0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (p !== 8'h00) begin n_fail++; $display("FAIL reset_p got %h want 00", p); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic acc, dlv, ov, ir;
        logic [7:0] pv;
        int e;
        cycle(1'b1, 4'd3, 4'd5, 1'b1, acc, dlv, ov, ir, pv);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept got %b want 1", acc); end
        cycle(1'b0, 4'd0, 4'd0, 1'b1, acc, dlv, ov, ir, pv);
        n_checks++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL single_early got out_valid %b want 0", ov); end
        cycle(1'b0, 4'd0, 4'd0, 1'b1, acc, dlv, ov, ir, pv);
        n_checks++;
        if (ov !== 1'b1 || pv !== 8'h0F) begin
            n_fail++; $display("FAIL single_latency2 got valid %b p %h want valid 1 p 0f", ov, pv);
        end
        if (dlv && exp_q.size() > 0) e = exp_q.pop_front();
        cycle(1'b0, 4'd0, 4'd0, 1'b1, acc, dlv, ov, ir, pv);
        n_checks++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL single_after got out_valid %b want 0", ov); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_queue got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_zero;
        logic acc, dlv, ov, ir;
        logic [7:0] pv;
        int cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      cycle(1'b1, 4'd0,  4'd15, 1'b1, acc, dlv, ov, ir, pv);
            else if (c == 1) cycle(1'b1, 4'd15, 4'd0,  1'b1, acc, dlv, ov, ir, pv);
            else             cycle(1'b0, 4'd0,  4'd0,  1'b1, acc, dlv, ov, ir, pv);
            if (dlv) begin
                cnt++;
                n_checks++;
                if (pv !== 8'h00) begin n_fail++; $display("FAIL zero_product got %h want 00", pv); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        n_checks++;
        if (cnt != 2) begin n_fail++; $display("FAIL zero_count got %0d want 2", cnt); end
    endtask

    task automatic test_sweep;
        logic acc, dlv, ov, ir;
        logic [7:0] pv;
        int e;
        for (int i = 0; i < 259; i++) begin
            if (i < 256) cycle(1'b1, 4'(i >> 4), 4'(i & 15), 1'b1, acc, dlv, ov, ir, pv);
            else         cycle(1'b0, 4'd0, 4'd0, 1'b1, acc, dlv, ov, ir, pv);
            if (i < 256) begin
                n_checks++;
                if (acc !== 1'b1) begin n_fail++; $display("FAIL sweep_accept i=%0d got %b want 1", i, acc); end
            end
            n_checks++;
            if (dlv !== (i >= 2 && i < 258)) begin
                n_fail++; $display("FAIL sweep_rate i=%0d got deliver %b want %b", i, dlv, (i >= 2 && i < 258));
            end
            if (dlv) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL sweep_extra i=%0d got p %h want none", i, pv);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (pv !== 8'(e)) begin n_fail++; $display("FAIL sweep_product i=%0d got %h want %h", i, pv, 8'(e)); end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sweep_lost got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_stall;
        logic acc, dlv, ov, ir, ordy;
        logic [7:0] pv;
        logic [3:0] pa[3];
        logic [3:0] pb[3];
        int got[$];
        int idx = 0;
        int e;
        pa[0] = 4'd10; pa[1] = 4'd7; pa[2] = 4'd12;
        pb[0] = 4'd10; pb[1] = 4'd9; pb[2] = 4'd4;
        for (int c = 0; c < 40; c++) begin
            ordy = (c == 0) || (c > 5);
            if (idx < 3) cycle(1'b1, pa[idx], pb[idx], ordy, acc, dlv, ov, ir, pv);
            else         cycle(1'b0, 4'd0, 4'd0, ordy, acc, dlv, ov, ir, pv);
            if (acc) idx++;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (ov !== 1'b1 || pv !== 8'd100 || ir !== 1'b0) begin
                    n_fail++; $display("FAIL stall_hold c=%0d got valid %b p %0d in_ready %b want 1 100 0", c, ov, pv, ir);
                end
            end
            if (dlv) begin
                got.push_back(int'(pv));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (pv !== 8'(e)) begin n_fail++; $display("FAIL stall_model got %0d want %0d", pv, e); end
                end
            end
            if (c > 5 && idx == 3 && got.size() == 3) break;
        end
        n_checks++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL stall_count got %0d want 3", got.size());
        end else begin
            n_checks++;
            if (got[0] != 100 || got[1] != 63 || got[2] != 48) begin
                n_fail++; $display("FAIL stall_order got %0d %0d %0d want 100 63 48", got[0], got[1], got[2]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random;
        logic acc, dlv, ov, ir, v, ordy;
        logic [7:0] pv;
        logic prev_stall = 1'b0;
        logic [7:0] prev_p = 8'h00;
        int accepted = 0;
        int delivered = 0;
        int e;
        for (int c = 0; c < 60000; c++) begin
            if (accepted >= 10000 && exp_q.size() == 0) break;
            v    = (accepted < 10000) && ($urandom % 4 != 0);
            ordy = ($urandom % 3 != 0);
            cycle(v, 4'($urandom), 4'($urandom), ordy, acc, dlv, ov, ir, pv);
            if (acc) accepted++;
            if (prev_stall) begin
                n_checks++;
                if (ov !== 1'b1 || pv !== prev_p) begin
                    n_fail++; $display("FAIL rand_stable c=%0d got valid %b p %h want 1 %h", c, ov, pv, prev_p);
                end
            end
            prev_stall = ov && !ordy;
            prev_p     = pv;
            if (dlv) begin
                delivered++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_dup c=%0d got p %h want none", c, pv);
                end else begin
                    e = exp_q.pop_front();
                    if (pv !== 8'(e)) begin n_fail++; $display("FAIL rand_product c=%0d got %h want %h", c, pv, 8'(e)); end
                end
            end
        end
        n_checks++;
        if (accepted != 10000 || delivered != 10000 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_totals got acc %0d dlv %0d pending %0d want 10000 10000 0",
                               accepted, delivered, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight;
        logic acc, dlv, ov, ir;
        logic [7:0] pv;
        cycle(1'b1, 4'd6, 4'd6, 1'b0, acc, dlv, ov, ir, pv);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL rst_fill1 got %b want 1", acc); end
        cycle(1'b1, 4'd9, 4'd2, 1'b0, acc, dlv, ov, ir, pv);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL rst_fill2 got %b want 1", acc); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || p !== 8'd36 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_full got valid %b p %0d in_ready %b want 1 36 0", out_valid, p, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || p !== 8'h00) begin
            n_fail++; $display("FAIL rst_async got valid %b p %h want 0 00", out_valid, p);
        end
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 4'd0, 4'd0, 1'b1, acc, dlv, ov, ir, pv);
            if (c == 0) begin
                n_checks++;
                if (ir !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", ir); end
            end
            n_checks++;
            if (dlv !== 1'b0) begin n_fail++; $display("FAIL rst_ghost c=%0d got p %0d want no delivery", c, pv); end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_sweep();
        test_stall();
        test_random();
        test_reset_midflight();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
